// File: rtl/cla_sub_32_pipe_if.sv
// cla_sub_32_pipe_if: stream bundle for the pipelined CLA subtractor.
//
// Handshake: a transfer happens on a rising clock edge when valid and ready
// are both high. A producer holding valid high keeps its payload stable until
// the transfer; ready may depend combinationally on the consumer's state.
//
// Signals:
//   in_valid / in_ready   operand stream (a, b, bin) into the subtractor
//   out_valid / out_ready result stream (diff, bout, ovf, zero) out of it
//
// Modports:
//   master  the side that supplies operands and consumes results
//   slave   the subtractor itself
interface cla_sub_32_pipe_if #(
   parameter int WIDTH = 32
);
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             bin;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] diff;
   logic             bout;
   logic             ovf;
   logic             zero;

   modport master (
      output in_valid, a, b, bin, out_ready,
      input  in_ready, out_valid, diff, bout, ovf, zero
   );

   modport slave (
      input  in_valid, a, b, bin, out_ready,
      output in_ready, out_valid, diff, bout, ovf, zero
   );
endinterface

// File: rtl/cla_sub_32_pipe.sv
// cla_sub_32_pipe: two-stage pipelined subtractor, diff = a - b - bin.
//
// Computed as a + ~b + ~bin with two WIDTH/2 carry-lookahead halves. The low
// half is evaluated on the incoming operands and registered together with the
// upper operand halves and the inter-half carry; the high half is evaluated
// from those registers in the second stage. A final carry of 0 means a borrow,
// so bout = ~carry, matching the adder's carry convention.
//
// Ports:
//   clk   rising-edge clock
//   rst   synchronous, active-high reset (clears both stages and all outputs)
//   bus   cla_sub_32_pipe_if.slave: in_valid/in_ready/a/b/bin in,
//         out_valid/out_ready/diff/bout/ovf/zero out (all outputs registered)
//
// Optional build macro CLA_SUB_32_SAT_EN: on signed overflow, diff is clamped
// to the most positive (a >= 0) or most negative (a < 0) value; bout and ovf
// still report the raw result. Without the macro diff wraps modulo 2^WIDTH.
module cla_sub_32_pipe #(
   parameter int WIDTH = 32
) (
   input logic              clk,
   input logic              rst,
   cla_sub_32_pipe_if.slave bus
);
   localparam int HW = WIDTH / 2;

   // Half-adder operands: index 0 is the low half (stage 1), 1 the high half.
   logic [HW-1:0] hx   [2];
   logic [HW-1:0] hy   [2];
   logic [HW-1:0] hsum [2];
   logic          hcin [2];
   logic          hcout[2];

   // Stage 1 registers
   logic          s1_valid;
   logic [HW-1:0] s1_a_hi;
   logic [HW-1:0] s1_b_hi;
   logic [HW-1:0] s1_lo;
   logic          s1_c;

   // Stage 2 registers (drive the outputs directly)
   logic             s2_valid;
   logic [WIDTH-1:0] s2_diff;
   logic             s2_bout;
   logic             s2_ovf;
   logic             s2_zero;

   logic s1_en;
   logic s2_en;

   // A stage may load when it is empty or its contents move on this edge.
   assign s2_en        = !s2_valid || bus.out_ready;
   assign s1_en        = !s1_valid || s2_en;
   assign bus.in_ready = s1_en;

   assign hx[0]   = bus.a[HW-1:0];
   assign hy[0]   = ~bus.b[HW-1:0];
   assign hcin[0] = ~bus.bin;
   assign hx[1]   = s1_a_hi;
   assign hy[1]   = ~s1_b_hi;
   assign hcin[1] = s1_c;

   // Each half: 4-bit lookahead groups. Within a group every carry is formed
   // directly from the group carry-in through prefix generate/propagate
   // terms; group carries chain from one group to the next. Per-bit scalars
   // in generate scopes keep the carry network free of vector feedback.
   for (genvar h = 0; h < 2; h++) begin : g_half
      logic [HW-1:0] g;
      logic [HW-1:0] p;

      assign g = hx[h] & hy[h];
      assign p = hx[h] ^ hy[h];

      for (genvar i = 0; i < HW; i++) begin : g_bit
         logic gg;   // generate of bits [group start .. i]
         logic pg;   // propagate of bits [group start .. i]
         logic gcin; // carry into the current 4-bit group
         logic ci;   // carry into this bit
         logic co;   // carry out of this bit

         if (i % 4 == 0) begin : g_head
            assign gg = g[i];
            assign pg = p[i];
         end else begin : g_tail
            assign gg = g[i] | (p[i] & g_bit[i-1].gg);
            assign pg = p[i] & g_bit[i-1].pg;
         end

         if (i < 4) begin : g_gc0
            assign gcin = hcin[h];
         end else begin : g_gcn
            assign gcin = g_bit[(i/4)*4 - 1].co;
         end

         if (i == 0) begin : g_ci0
            assign ci = hcin[h];
         end else begin : g_cin
            assign ci = g_bit[i-1].co;
         end

         assign co         = gg | (pg & gcin);
         assign hsum[h][i] = p[i] ^ ci;
      end

      assign hcout[h] = g_bit[HW-1].co;
   end

   // Stage 2 next-state: assemble the result and derive the flags.
   logic [WIDTH-1:0] raw_n;
   logic [WIDTH-1:0] diff_n;
   logic             a_neg;
   logic             b_neg;
   logic             ovf_n;
   logic             zero_n;
   logic             bout_n;

   always_comb begin
      raw_n  = {hsum[1], s1_lo};
      a_neg  = s1_a_hi[HW-1];
      b_neg  = s1_b_hi[HW-1];
      // Subtraction overflows only when operand signs differ and the result
      // sign disagrees with the minuend.
      ovf_n  = (a_neg != b_neg) && (raw_n[WIDTH-1] != a_neg);
      diff_n = raw_n;
`ifdef CLA_SUB_32_SAT_EN
      if (ovf_n) begin
         diff_n = a_neg ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
      end
`else
`endif
      zero_n = (diff_n == '0);
      bout_n = ~hcout[1];
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         s1_valid <= 1'b0;
         s1_a_hi  <= '0;
         s1_b_hi  <= '0;
         s1_lo    <= '0;
         s1_c     <= 1'b0;
      end else if (s1_en) begin
         s1_valid <= bus.in_valid;
         // Operands are only captured with a real transfer.
         if (bus.in_valid) begin
            s1_a_hi <= bus.a[WIDTH-1:HW];
            s1_b_hi <= bus.b[WIDTH-1:HW];
            s1_lo   <= hsum[0];
            s1_c    <= hcout[0];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         s2_valid <= 1'b0;
         s2_diff  <= '0;
         s2_bout  <= 1'b0;
         s2_ovf   <= 1'b0;
         s2_zero  <= 1'b0;
      end else if (s2_en) begin
         s2_valid <= s1_valid;
         if (s1_valid) begin
            s2_diff <= diff_n;
            s2_bout <= bout_n;
            s2_ovf  <= ovf_n;
            s2_zero <= zero_n;
         end
      end
   end

   assign bus.out_valid = s2_valid;
   assign bus.diff      = s2_diff;
   assign bus.bout      = s2_bout;
   assign bus.ovf       = s2_ovf;
   assign bus.zero      = s2_zero;
endmodule

// File: doc/cla_sub_32_pipe.md
Name: cla_sub_32_pipe

Overview:
- Two-stage pipelined 32-bit subtractor: diff = a - b - bin. Borrow in and borrow out use the same bit-level convention as the 32-bit CLA adder's carries.
- Built from two 16-bit carry-lookahead halves, computed as a + ~b + ~bin.
- Low half is computed in stage 1; high half in stage 2, using the registered inter-half carry.
- Sits beside the adder in the datapath and returns results through a valid/ready stream with backpressure.

Parameters:
- WIDTH, 32, operand width; must be even. The half split is WIDTH/2.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-high reset
- in_valid  input  1  operands present
- in_ready  output  1  block accepts operands this cycle
- a  input  WIDTH  minuend
- b  input  WIDTH  subtrahend
- bin  input  1  borrow in (1 = subtract an extra 1)
- out_valid  output  1  result present
- out_ready  input  1  downstream accepts result
- diff  output  WIDTH  a - b - bin, modulo 2^WIDTH
- bout  output  1  unsigned borrow out: 1 when a < b + bin
- ovf  output  1  signed two's-complement overflow
- zero  output  1  diff == 0

Behaviour:
- Transfers:
  - Input transfer occurs when in_valid && in_ready.
  - Output transfer occurs when out_valid && out_ready.
- Stage 1 (s1), registered on an input transfer:
  - lo = a[15:0] + ~b[15:0] + ~bin, giving a 16-bit result and carry c16.
  - Also registers a[31:16], b[31:16], lo, c16 and s1_valid.
- Stage 2 (s2), registered when s1 advances:
  - hi = a_hi + ~b_hi + c16, giving a 16-bit result and carry c32.
  - diff = {hi, lo}.
  - bout = ~c32.
  - ovf = (a[31] != b[31]) && (diff[31] != a[31]), using the registered sign bits.
  - zero = (diff == 0).
  - All outputs come directly from registers.
- Latency: exactly 2 cycles from input transfer to out_valid when out_ready stays high. Throughput is 1 result per cycle.
- Backpressure:
  - s2_en = !s2_valid || out_ready.
  - s1_en = !s1_valid || s2_en.
  - in_ready = s1_en, which is combinational from out_ready. There is no skid buffer.
  - With out_ready low and both stages full: in_ready = 0 and every register holds. diff, bout, ovf and zero stay stable while out_valid = 1 and out_ready = 0.
- Valid bookkeeping:
  - s2_valid is set from s1_valid when s2_en.
  - s1_valid is set from in_valid when s1_en.
  - Simultaneous output transfer and stage-1 advance in the same cycle is legal and loses no data.
- Reset (rst = 1 at a clock edge):
  - s1_valid = 0, s2_valid = 0, out_valid = 0.
  - diff = 0, bout = 0, ovf = 0, zero = 0.
  - in_ready = 1 in the first cycle after reset.
  - Reset mid-operation discards all in-flight data. Outputs hold no stale values.
- Wrap-around: the result is modulo 2^32. 0 - 1 gives 0xFFFFFFFF with bout = 1.
- bin = 1 with a == b gives 0xFFFFFFFF, bout = 1, ovf = 0.
- Operand inputs are ignored when in_valid = 0.

Optional Feature:
- Macro: CLA_SUB_32_SAT_EN.
- Defined:
  - When ovf = 1, diff is clamped to 0x7FFFFFFF if a is non-negative, or 0x80000000 if a is negative.
  - ovf still reports the overflow.
  - zero is computed on the clamped value, so it is 0.
  - bout is unchanged (raw unsigned borrow).
  - Clamping happens at the s2 register input; latency is unchanged.
- Undefined: diff is the raw wrapped result and the clamp logic is absent.

Test Plan:
- Reset, then a = 0x00000005, b = 0x00000003, bin = 0, out_ready = 1 → 2 cycles later: out_valid = 1, diff = 0x00000002, bout = 0, ovf = 0, zero = 0.
- a = 0x00000000, b = 0x00000001, bin = 0 → diff = 0xFFFFFFFF, bout = 1, ovf = 0. Separately, a = 0x0000FFFF, b = 0xFFFFFFFF, bin = 1 → diff = 0x0000FFFF, bout = 1, exercising the inter-half carry.
- a = 0x80000000, b = 0x00000001 → diff = 0x7FFFFFFF, ovf = 1, bout = 0. With CLA_SUB_32_SAT_EN: diff = 0x80000000, zero = 0.
- Back-to-back stream of 8 operand pairs with out_ready = 1 → 8 results in order on consecutive cycles. in_ready stays 1 throughout. a = b gives zero = 1.
- Stream of 4 operand pairs; hold out_ready = 0 for 5 cycles after the first result appears → in_ready drops once both stages are full, outputs stay stable, and all 4 results arrive in order after release.
- Assert rst with both stages full → next cycle out_valid = 0 and diff = 0. The first new input after release produces only its own result.
